// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_REQ valid/ready streams into one,
// holding the grant from a packet's first beat until its last beat is accepted.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          out_last_o,
  output logic [ID_WIDTH-1:0]           out_id_o,
  output logic                          busy_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic [ID_WIDTH-1:0] r_gnt, w_gnt_nxt;
  logic [ID_WIDTH-1:0] w_hi, w_lo, w_rr_gnt, w_gnt, w_gnt_inc;
  logic                w_hi_found, w_lo_found;
  logic                w_sel_valid, w_hs;

  // Round-robin scan: lowest valid index at or above ptr, else lowest valid overall.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        w_lo       = ID_WIDTH'(i);
        w_lo_found = 1'b1;
        if (i >= int'(r_ptr)) begin
          w_hi       = ID_WIDTH'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    if (w_hi_found)      w_rr_gnt = w_hi;
    else if (w_lo_found) w_rr_gnt = w_lo;
    else                 w_rr_gnt = r_ptr;
  end

  assign w_gnt     = (r_state == ST_LOCKED) ? r_gnt : w_rr_gnt;
  assign w_gnt_inc = (w_gnt == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt + ID_WIDTH'(1);

  // In IDLE the scan only lands on a valid requester when any is valid, so the
  // granted requester's valid equals |req_valid_i there; one mux serves both states.
  always_comb begin
    out_data_o  = '0;
    out_last_o  = 1'b0;
    w_sel_valid = 1'b0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == w_gnt) begin
        out_data_o     = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        out_last_o     = req_last_i[i];
        w_sel_valid    = req_valid_i[i];
        req_ready_o[i] = out_ready_i && req_valid_i[i];
      end
    end
  end

  assign out_valid_o = w_sel_valid;
  assign out_id_o    = w_gnt;
  assign busy_o      = (r_state == ST_LOCKED);
  assign w_hs        = out_valid_o && out_ready_i;

  // Lock on any offered beat that does not complete a packet, including a stalled
  // first beat, so the offered beat cannot change under backpressure.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hs && out_last_o) begin
          w_ptr_nxt = w_gnt_inc;
        end else if (out_valid_o) begin
          w_state_nxt = ST_LOCKED;
          w_gnt_nxt   = w_gnt;
        end
      end
      ST_LOCKED: begin
        if (w_hs && out_last_o) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_gnt_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: a 4-requester instance plus a 3-requester
// instance for the non-power-of-two wrap.
module tb_stream_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [3:0]   a_valid, a_ready, a_last;
  logic [127:0] a_data;
  logic         a_ovalid, a_oready, a_olast, a_busy;
  logic [31:0]  a_odata;
  logic [1:0]   a_oid;

  // 3-requester instance
  logic [2:0]   b_valid, b_ready, b_last;
  logic [23:0]  b_data;
  logic         b_ovalid, b_oready, b_olast, b_busy;
  logic [7:0]   b_odata;
  logic [1:0]   b_oid;

  int n_pass  = 0;
  int n_total = 0;

  stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ID_WIDTH(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_data_i(a_data), .req_last_i(a_last),
    .out_valid_o(a_ovalid), .out_ready_i(a_oready), .out_data_o(a_odata),
    .out_last_o(a_olast), .out_id_o(a_oid), .busy_o(a_busy)
  );

  stream_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .ID_WIDTH(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_data_i(b_data), .req_last_i(b_last),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready), .out_data_o(b_odata),
    .out_last_o(b_olast), .out_id_o(b_oid), .busy_o(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = '0; a_last = '0; a_data = '0; a_oready = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_oready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_a_data(input int i, input logic [31:0] d);
    a_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++; if (a_ovalid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_ovalid); else n_pass++;
    n_total++; if (a_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", a_ready); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_oid !== 2'd0) $display("FAIL reset_out_id: got %0d want 0", a_oid); else n_pass++;
    n_total++; if (a_olast !== 1'b0) $display("FAIL reset_out_last: got %b want 0", a_olast); else n_pass++;
    n_total++; if (a_odata !== 32'h0) $display("FAIL reset_out_data: got %h want 0", a_odata); else n_pass++;
    step();
  endtask

  task automatic test_single_beat();
    do_reset();
    a_valid = 4'b0100; a_last = 4'b0100; a_oready = 1'b1;
    set_a_data(2, 32'hA5);
    @(negedge clk);
    n_total++; if (a_ovalid !== 1'b1) $display("FAIL single_valid: got %b want 1", a_ovalid); else n_pass++;
    n_total++; if (a_oid !== 2'd2) $display("FAIL single_id: got %0d want 2", a_oid); else n_pass++;
    n_total++; if (a_odata !== 32'hA5) $display("FAIL single_data: got %h want a5", a_odata); else n_pass++;
    n_total++; if (a_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", a_ready); else n_pass++;
    step();
    a_valid = 4'b0000;
    @(negedge clk);
    // With nothing valid the id output shows ptr, which must now be 3.
    n_total++; if (a_oid !== 2'd3) $display("FAIL single_ptr_next: got %0d want 3", a_oid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL single_busy_next: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_ovalid !== 1'b0) $display("FAIL single_idle_valid: got %b want 0", a_ovalid); else n_pass++;
    step();
  endtask

  task automatic test_rotation();
    do_reset();
    a_valid = 4'b1111; a_last = 4'b1111; a_oready = 1'b1;
    for (int i = 0; i < 4; i++) set_a_data(i, 32'h10 + i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_total++; if (a_ovalid !== 1'b1) $display("FAIL rot_valid[%0d]: got %b want 1", k, a_ovalid); else n_pass++;
      n_total++; if (a_oid !== 2'(k % 4)) $display("FAIL rot_id[%0d]: got %0d want %0d", k, a_oid, k % 4); else n_pass++;
      n_total++; if (a_odata !== 32'(32'h10 + k % 4)) $display("FAIL rot_data[%0d]: got %h want %h", k, a_odata, 32'h10 + k % 4); else n_pass++;
      step();
    end
    clear_inputs();
  endtask

  task automatic test_multi_beat();
    do_reset();
    // Requester 0 sends one beat first so ptr sits at 1.
    a_valid = 4'b0001; a_last = 4'b0001; a_oready = 1'b1;
    @(negedge clk);
    n_total++; if (a_oid !== 2'd0) $display("FAIL mb_pre_id: got %0d want 0", a_oid); else n_pass++;
    step();
    a_valid = 4'b0111; a_last = 4'b0101;
    set_a_data(0, 32'h0000_00F0); set_a_data(2, 32'h0000_00F2);
    for (int b = 1; b <= 3; b++) begin
      set_a_data(1, 32'hB0 + b);
      if (b == 3) a_last = 4'b0111;
      @(negedge clk);
      n_total++; if (a_oid !== 2'd1) $display("FAIL mb_id[%0d]: got %0d want 1", b, a_oid); else n_pass++;
      n_total++; if (a_odata !== 32'(32'hB0 + b)) $display("FAIL mb_data[%0d]: got %h want %h", b, a_odata, 32'hB0 + b); else n_pass++;
      n_total++; if (a_busy !== (b != 1)) $display("FAIL mb_busy[%0d]: got %b want %b", b, a_busy, b != 1); else n_pass++;
      step();
    end
    @(negedge clk);
    n_total++; if (a_oid !== 2'd2) $display("FAIL mb_after_id: got %0d want 2", a_oid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL mb_after_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_ready !== 4'b0100) $display("FAIL mb_after_ready: got %b want 0100", a_ready); else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    a_valid = 4'b1000; a_last = 4'b1111; a_oready = 1'b0;
    set_a_data(3, 32'hDEAD_0003); set_a_data(0, 32'hDEAD_0000);
    @(negedge clk);
    n_total++; if (a_oid !== 2'd3) $display("FAIL bp_first_id: got %0d want 3", a_oid); else n_pass++;
    n_total++; if (a_ovalid !== 1'b1) $display("FAIL bp_first_valid: got %b want 1", a_ovalid); else n_pass++;
    n_total++; if (a_ready !== 4'b0000) $display("FAIL bp_first_ready: got %b want 0000", a_ready); else n_pass++;
    step();
    a_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++; if (a_oid !== 2'd3) $display("FAIL bp_stall_id[%0d]: got %0d want 3", c, a_oid); else n_pass++;
      n_total++; if (a_odata !== 32'hDEAD_0003) $display("FAIL bp_stall_data[%0d]: got %h want dead0003", c, a_odata); else n_pass++;
      n_total++; if (a_busy !== 1'b1) $display("FAIL bp_stall_busy[%0d]: got %b want 1", c, a_busy); else n_pass++;
      n_total++; if (a_ready !== 4'b0000) $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, a_ready); else n_pass++;
      step();
    end
    a_oready = 1'b1;
    @(negedge clk);
    n_total++; if (a_ready !== 4'b1000) $display("FAIL bp_release_ready: got %b want 1000", a_ready); else n_pass++;
    n_total++; if (a_oid !== 2'd3) $display("FAIL bp_release_id: got %0d want 3", a_oid); else n_pass++;
    step();
    a_valid = 4'b0001;
    @(negedge clk);
    n_total++; if (a_oid !== 2'd0) $display("FAIL bp_next_id: got %0d want 0", a_oid); else n_pass++;
    n_total++; if (a_ready !== 4'b0001) $display("FAIL bp_next_ready: got %b want 0001", a_ready); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL bp_next_busy: got %b want 0", a_busy); else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_three_req_wrap();
    do_reset();
    b_valid = 3'b111; b_last = 3'b111; b_oready = 1'b1;
    b_data = {8'hC2, 8'hC1, 8'hC0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total++; if (b_oid !== 2'(k % 3)) $display("FAIL n3_id[%0d]: got %0d want %0d", k, b_oid, k % 3); else n_pass++;
      n_total++; if (b_odata !== 8'(8'hC0 + k % 3)) $display("FAIL n3_data[%0d]: got %h want %h", k, b_odata, 8'hC0 + k % 3); else n_pass++;
      n_total++; if (b_olast !== 1'b1) $display("FAIL n3_last[%0d]: got %b want 1", k, b_olast); else n_pass++;
      step();
    end
    b_valid = 3'b000;
    @(negedge clk);
    n_total++; if (b_oid !== 2'd0) $display("FAIL n3_ptr_wrap: got %0d want 0", b_oid); else n_pass++;
    n_total++; if (b_busy !== 1'b0) $display("FAIL n3_busy: got %b want 0", b_busy); else n_pass++;
    n_total++; if (b_ready !== 3'b000) $display("FAIL n3_idle_ready: got %b want 000", b_ready); else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_mid_packet_reset();
    do_reset();
    a_valid = 4'b0100; a_last = 4'b0000; a_oready = 1'b1;
    @(negedge clk);
    n_total++; if (a_busy !== 1'b0) $display("FAIL mr_beat1_busy: got %b want 0", a_busy); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (a_busy !== 1'b1) $display("FAIL mr_beat2_busy: got %b want 1", a_busy); else n_pass++;
    n_total++; if (a_oid !== 2'd2) $display("FAIL mr_beat2_id: got %0d want 2", a_oid); else n_pass++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_valid = 4'b1111; a_last = 4'b1111;
    @(negedge clk);
    n_total++; if (a_busy !== 1'b0) $display("FAIL mr_after_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_oid !== 2'd0) $display("FAIL mr_after_id: got %0d want 0", a_oid); else n_pass++;
    n_total++; if (a_ready !== 4'b0001) $display("FAIL mr_after_ready: got %b want 0001", a_ready); else n_pass++;
    step();
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_beat();
    test_rotation();
    test_multi_beat();
    test_backpressure();
    test_three_req_wrap();
    test_mid_packet_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Packet-level round-robin arbiter that merges NUM_REQ valid/ready streams into one output stream, typically ahead of a shared `stream_fifo_flow_true` or any single-consumer datapath. A packet is one or more beats terminated by `last`; once a requester wins, it keeps the output until its `last` beat is accepted. Selection is zero-latency (flow-through) when the arbiter is idle, so an uncontended requester sees no added cycle.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16, need not be a power of two)
- DATA_WIDTH, 32, beat payload width
- ID_WIDTH, 2, width of requester index; must satisfy 2^ID_WIDTH >= NUM_REQ

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_ready_o  out  NUM_REQ  per-requester beat accept
- req_data_i  in  NUM_REQ*DATA_WIDTH  payloads, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last_i  in  NUM_REQ  per-requester end-of-packet flag
- out_valid_o  out  1  merged beat valid
- out_ready_i  in  1  downstream accept
- out_data_o  out  DATA_WIDTH  payload of granted requester
- out_last_o  out  1  last flag of granted requester
- out_id_o  out  ID_WIDTH  index of granted requester
- busy_o  out  1  high while in LOCKED

## Operation
- State: `st` in {IDLE, LOCKED}; `ptr` (ID_WIDTH) = highest-priority requester; `gnt_r` (ID_WIDTH) = locked requester.
- Reset: st=IDLE, ptr=0, gnt_r=0. Outputs right after reset with no requests: out_valid_o=0, req_ready_o=0, busy_o=0, out_id_o=0, out_last_o=0, out_data_o=0.
- IDLE selection (combinational): `gnt` = first i with req_valid_i[i], scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1. out_valid_o = |req_valid_i. With no valid request, gnt=ptr and data/last/id outputs are those of ptr.
- LOCKED selection: gnt = gnt_r regardless of other requests; out_valid_o = req_valid_i[gnt_r].
- Muxing in both states: out_data_o/out_last_o/out_id_o from gnt; req_ready_o[i] = out_ready_i && out_valid_o && (i == gnt); all other readys 0.
- Handshake `hs` = out_valid_o && out_ready_i.
- Transitions:
  - IDLE, hs && last: stay IDLE, ptr <= (gnt+1) mod NUM_REQ.
  - IDLE, out_valid_o and not (hs && last): go LOCKED, gnt_r <= gnt (locks both for multi-beat packets and for a stalled first beat, so the offered beat never changes under backpressure).
  - IDLE, no valid: stay, nothing changes.
  - LOCKED, hs && last: go IDLE, ptr <= (gnt_r+1) mod NUM_REQ.
  - LOCKED otherwise: stay; gaps in the locked requester's valid are allowed and simply drive out_valid_o=0.
- Wrap: ptr increments from NUM_REQ-1 to 0; values >= NUM_REQ never occur.
- Fairness: each requester waits at most NUM_REQ-1 packets of others.

## Timing
- IDLE: zero-cycle path req_valid_i→out_valid_o and out_ready_i→req_ready_o; a beat can be accepted the same cycle it is offered.
- LOCKED: same combinational paths, restricted to gnt_r.
- Single-beat packets from alternating requesters sustain 1 beat/cycle with no bubbles.
- New ptr/state take effect on the cycle after the `last` handshake; the next winner can be granted that cycle.
- rst asserted mid-packet: next cycle IDLE, ptr=0; the interrupted packet is not completed. Upstream/downstream must be reset together.

## Test plan
- Reset, then req_valid_i=4'b0100 single beat, data 0xA5, last=1, out_ready_i=1 → same cycle out_valid_o=1, out_id_o=2, out_data_o=0xA5, req_ready_o=4'b0100; next cycle ptr=3, busy_o=0.
- All four valid, single-beat packets, out_ready_i=1 for 8 cycles → out_id_o sequence 0,1,2,3,0,1,2,3, no bubbles.
- Req 1 sends 3-beat packet (last on beat 3) while req 0 and 2 stay valid → ids 1,1,1 then 2; busy_o=1 during beats 2-3 only.
- Req 3 valid, out_ready_i=0 for 4 cycles while req 0 then raises valid → out_id_o stays 3, out_data_o stable, busy_o=1; on ready, req 3 accepted, then req 0 next.
- NUM_REQ=3, ID_WIDTH=2, all valid, 6 single beats → ids 0,1,2,0,1,2 (ptr never reaches 3).
- Req 2 mid 4-beat packet after 2 beats, rst=1 one cycle → next cycle busy_o=0, ptr=0; with all valid, first grant is id 0.
